// File: rtl/ct_mmu_sysmap_pkg.sv
// Shared sysmap definitions: geometry, flag reset value and the config FSM state type.
// Also used by the sysmap hit logic, so widths here must stay in sync with it.
package ct_mmu_sysmap_pkg;

  localparam int unsigned REGION_NUM = 8;
  localparam int unsigned ADDR_W     = 28;
  localparam int unsigned FLG_W      = 5;

  localparam logic [FLG_W-1:0] FLG_RST = 5'b01111;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StNotify
  } sysmap_state_e;

endpackage

// File: rtl/ct_mmu_sysmap_ordchk.sv
// Region ordering checker: flags an upaddr write that would break the ascending
// order of region upper bounds. Equal neighbours are allowed.
// Only instantiated when SYSMAP_ORDER_CHK_EN is defined.
module ct_mmu_sysmap_ordchk
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int unsigned REGION_NUM = ct_mmu_sysmap_pkg::REGION_NUM,
  parameter int unsigned ADDR_W     = ct_mmu_sysmap_pkg::ADDR_W
) (
  input  logic [REGION_NUM*ADDR_W-1:0] upaddr_flat,
  input  logic [2:0]                   sel,
  input  logic                         is_upaddr,
  input  logic [ADDR_W-1:0]            data,
  output logic                         reject
);

  int unsigned       sel_n;
  int unsigned       lo_idx;
  int unsigned       hi_idx;
  logic [ADDR_W-1:0] lo_bound;
  logic [ADDR_W-1:0] hi_bound;
  logic              has_lo;
  logic              has_hi;

  // Fetch neighbour bounds; indices are clamped so edge regions never read out of range.
  always_comb begin
    sel_n    = 32'(sel);
    has_lo   = (sel_n != 0);
    has_hi   = (sel_n < REGION_NUM - 1);
    lo_idx   = has_lo ? sel_n - 1 : 0;
    hi_idx   = has_hi ? sel_n + 1 : REGION_NUM - 1;
    lo_bound = upaddr_flat[lo_idx*ADDR_W +: ADDR_W];
    hi_bound = upaddr_flat[hi_idx*ADDR_W +: ADDR_W];
    reject   = is_upaddr && ((has_lo && (data < lo_bound)) || (has_hi && (data > hi_bound)));
  end

endmodule

// File: rtl/ct_mmu_sysmap_cfg.sv
// Sysmap region configuration: stages a cp0 write, waits for in-flight MMU lookups to
// drain, commits the field, then acknowledges and signals a uTLB invalidate.
// Optional: SYSMAP_ORDER_CHK_EN enables rejection of out-of-order upaddr writes.
module ct_mmu_sysmap_cfg #(
  parameter int unsigned REGION_NUM = ct_mmu_sysmap_pkg::REGION_NUM,
  parameter int unsigned ADDR_W     = ct_mmu_sysmap_pkg::ADDR_W,
  parameter int unsigned FLG_W      = ct_mmu_sysmap_pkg::FLG_W
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst,
  input  logic                         cp0_sysmap_wen,
  input  logic [2:0]                   cp0_sysmap_wsel,
  input  logic                         cp0_sysmap_wfield,
  input  logic [ADDR_W-1:0]            cp0_sysmap_wdata,
  input  logic                         mmu_sysmap_lookup_busy,
  output logic                         sysmap_cp0_wack,
  output logic                         sysmap_cp0_werr,
  output logic [REGION_NUM*ADDR_W-1:0] sysmap_mmu_upaddr_flat,
  output logic [REGION_NUM*FLG_W-1:0]  sysmap_mmu_flg_flat,
  output logic                         sysmap_mmu_update_pend,
  output logic                         sysmap_mmu_cfg_chg
);

  import ct_mmu_sysmap_pkg::*;

  sysmap_state_e     state;
  logic [2:0]        stg_sel;
  logic              stg_field;
  logic [ADDR_W-1:0] stg_data;
  logic [ADDR_W-1:0] upaddr [REGION_NUM];
  logic [FLG_W-1:0]  flg    [REGION_NUM];
  logic              reject;

  for (genvar i = 0; i < REGION_NUM; i++) begin : g_flat
    assign sysmap_mmu_upaddr_flat[i*ADDR_W +: ADDR_W] = upaddr[i];
    assign sysmap_mmu_flg_flat[i*FLG_W +: FLG_W]      = flg[i];
  end

`ifdef SYSMAP_ORDER_CHK_EN
  logic werr;

  ct_mmu_sysmap_ordchk #(
    .REGION_NUM (REGION_NUM),
    .ADDR_W     (ADDR_W)
  ) u_ordchk (
    .upaddr_flat (sysmap_mmu_upaddr_flat),
    .sel         (stg_sel),
    .is_upaddr   (!stg_field),
    .data        (stg_data),
    .reject      (reject)
  );

  // Rejection pulse, registered alongside wack so both land in the NOTIFY cycle.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      werr <= 1'b0;
    end else begin
      werr <= (state == StCommit) && reject;
    end
  end

  assign sysmap_cp0_werr = werr;
`else
  assign reject          = 1'b0;
  assign sysmap_cp0_werr = 1'b0;
`endif

  // Config FSM with registered handshake outputs and the region register file.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state                  <= StIdle;
      stg_sel                <= '0;
      stg_field              <= 1'b0;
      stg_data               <= '0;
      sysmap_cp0_wack        <= 1'b0;
      sysmap_mmu_cfg_chg     <= 1'b0;
      sysmap_mmu_update_pend <= 1'b0;
      for (int i = 0; i < REGION_NUM; i++) begin
        upaddr[i] <= '1;
        flg[i]    <= FLG_W'(FLG_RST);
      end
    end else begin
      sysmap_cp0_wack    <= 1'b0;
      sysmap_mmu_cfg_chg <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cp0_sysmap_wen) begin
            stg_sel                <= cp0_sysmap_wsel;
            stg_field              <= cp0_sysmap_wfield;
            stg_data               <= cp0_sysmap_wdata;
            sysmap_mmu_update_pend <= 1'b1;
            state                  <= StDrain;
          end
        end
        StDrain: begin
          // Registers must not move while a lookup may still be reading them.
          if (!mmu_sysmap_lookup_busy) begin
            state <= StCommit;
          end
        end
        StCommit: begin
          if (!reject) begin
            if (stg_field) begin
              flg[stg_sel] <= stg_data[FLG_W-1:0];
            end else begin
              upaddr[stg_sel] <= stg_data;
            end
            sysmap_mmu_cfg_chg <= 1'b1;
          end
          sysmap_cp0_wack <= 1'b1;
          state           <= StNotify;
        end
        StNotify: begin
          sysmap_mmu_update_pend <= 1'b0;
          state                  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_mmu_sysmap_cfg.sv
// Directed bench for ct_mmu_sysmap_cfg with a scoreboard of expected commit results.
// Follows SYSMAP_ORDER_CHK_EN in its reference model.
module tb_ct_mmu_sysmap_cfg;

  localparam int RN = 8;
  localparam int AW = 28;
  localparam int FW = 5;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          wen   = 1'b0;
  logic [2:0]    wsel  = '0;
  logic          wfield = 1'b0;
  logic [AW-1:0] wdata = '0;
  logic          busy  = 1'b0;
  logic          wack;
  logic          werr;
  logic [RN*AW-1:0] up_flat;
  logic [RN*FW-1:0] flg_flat;
  logic          pend;
  logic          cfg_chg;

  ct_mmu_sysmap_cfg dut (
    .forever_cpuclk         (clk),
    .cpurst                 (rst),
    .cp0_sysmap_wen         (wen),
    .cp0_sysmap_wsel        (wsel),
    .cp0_sysmap_wfield      (wfield),
    .cp0_sysmap_wdata       (wdata),
    .mmu_sysmap_lookup_busy (busy),
    .sysmap_cp0_wack        (wack),
    .sysmap_cp0_werr        (werr),
    .sysmap_mmu_upaddr_flat (up_flat),
    .sysmap_mmu_flg_flat    (flg_flat),
    .sysmap_mmu_update_pend (pend),
    .sysmap_mmu_cfg_chg     (cfg_chg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             werr;
    logic             cfg_chg;
    logic [RN*AW-1:0] up;
    logic [RN*FW-1:0] flg;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_up  [RN];
  logic [FW-1:0] m_flg [RN];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RN*AW-1:0] pack_up();
    logic [RN*AW-1:0] r;
    for (int i = 0; i < RN; i++) r[i*AW +: AW] = m_up[i];
    return r;
  endfunction

  function automatic logic [RN*FW-1:0] pack_flg();
    logic [RN*FW-1:0] r;
    for (int i = 0; i < RN; i++) r[i*FW +: FW] = m_flg[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RN; i++) begin
      m_up[i]  = 28'hFFFFFFF;
      m_flg[i] = 5'b01111;
    end
  endtask

  // Predict the outcome of a write against the current model and queue it.
  task automatic push_exp(input int sel, input bit field, input logic [AW-1:0] data);
    logic [AW-1:0] up  [RN];
    logic [FW-1:0] fl  [RN];
    bit            rej = 1'b0;
    exp_t          e;
    for (int i = 0; i < RN; i++) begin
      up[i] = m_up[i];
      fl[i] = m_flg[i];
    end
`ifdef SYSMAP_ORDER_CHK_EN
    if (!field) begin
      if (sel > 0) begin
        if (data < up[sel-1]) rej = 1'b1;
      end
      if (sel < RN - 1) begin
        if (data > up[sel+1]) rej = 1'b1;
      end
    end
`endif
    if (!rej) begin
      if (field) fl[sel] = data[FW-1:0];
      else up[sel] = data;
    end
    e.werr    = rej;
    e.cfg_chg = !rej;
    for (int i = 0; i < RN; i++) begin
      e.up[i*AW +: AW]  = up[i];
      e.flg[i*FW +: FW] = fl[i];
    end
    sb.push_back(e);
  endtask

  // Count cycles to wack; outputs must hold the old values until then.
  task automatic wait_ack(input int lat, input int busy_cycles, input int drop_at, input bit hold);
    int   k   = 0;
    bit   got = 1'b0;
    exp_t e;
    while (!got && k < 20) begin
      tick();
      k++;
      busy = (k <= busy_cycles);
      if (k == drop_at) wen = 1'b0;
      if (wack === 1'b1) begin
        got = 1'b1;
      end else begin
        chk("pend_busy", 256'(pend), 256'(k > lat - 3 - busy_cycles));
        chk("up_stable", 256'(up_flat), 256'(pack_up()));
        chk("flg_stable", 256'(flg_flat), 256'(pack_flg()));
      end
    end
    busy = 1'b0;
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL ack_timeout observed=no_wack expected=wack_by_cycle_%0d", lat);
    end
    if (got) begin
      e = sb.pop_front();
      chk("latency", 256'(k), 256'(lat));
      chk("werr", 256'(werr), 256'(e.werr));
      chk("cfg_chg", 256'(cfg_chg), 256'(e.cfg_chg));
      chk("pend_notify", 256'(pend), 256'(1));
      chk("up_notify", 256'(up_flat), 256'(e.up));
      chk("flg_notify", 256'(flg_flat), 256'(e.flg));
      for (int i = 0; i < RN; i++) begin
        m_up[i]  = e.up[i*AW +: AW];
        m_flg[i] = e.flg[i*FW +: FW];
      end
      if (!hold) wen = 1'b0;
    end
  endtask

  task automatic idle_chk();
    tick();
    chk("wack_idle", 256'(wack), 256'(0));
    chk("werr_idle", 256'(werr), 256'(0));
    chk("cfg_idle", 256'(cfg_chg), 256'(0));
    chk("pend_idle", 256'(pend), 256'(0));
  endtask

  task automatic do_write(input int sel, input bit field, input logic [AW-1:0] data,
                          input int busy_cycles);
    wen    = 1'b1;
    wsel   = 3'(sel);
    wfield = field;
    wdata  = data;
    push_exp(sel, field, data);
    wait_ack(3 + busy_cycles, busy_cycles, 0, 1'b0);
    idle_chk();
  endtask

  initial begin
    logic [RN*AW-1:0] rst_up;
    logic [RN*FW-1:0] rst_flg;
    rst_up  = {RN{28'hFFFFFFF}};
    rst_flg = {RN{5'b01111}};
    model_reset();

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_up", 256'(up_flat), 256'(rst_up));
    chk("rst_flg", 256'(flg_flat), 256'(rst_flg));
    chk("rst_pend", 256'(pend), 256'(0));
    chk("rst_wack", 256'(wack), 256'(0));
    chk("rst_werr", 256'(werr), 256'(0));
    chk("rst_cfg", 256'(cfg_chg), 256'(0));

    // Reset landing in DRAIN drops the staged write.
    wen    = 1'b1;
    wsel   = 3'd3;
    wfield = 1'b0;
    wdata  = 28'h0001234;
    tick();
    chk("drain_pend", 256'(pend), 256'(1));
    rst = 1'b1;
    wen = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstdrain_pend", 256'(pend), 256'(0));
    chk("rstdrain_wack", 256'(wack), 256'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstdrain_nowack", 256'(wack), 256'(0));
    end
    chk("rstdrain_up", 256'(up_flat), 256'(rst_up));
    chk("rstdrain_flg", 256'(flg_flat), 256'(rst_flg));

    // Plain upaddr write, no drain stall.
    do_write(7, 1'b0, 28'h0080000, 0);
    // Flag write with four busy cycles.
    do_write(2, 1'b1, 28'h0000003, 4);

    // Build an ordered map, then attempt an out-of-order upaddr write.
    do_write(0, 1'b0, 28'h0000080, 0);
    do_write(1, 1'b0, 28'h0000100, 0);
    do_write(2, 1'b0, 28'h0000300, 1);
    do_write(1, 1'b0, 28'h0000400, 0);
    // Equal-to-neighbour bound is accepted.
    do_write(1, 1'b0, 28'h0000300, 2);
    // Flag write only uses low bits of wdata.
    do_write(0, 1'b1, 28'hFFFFFEA, 0);

    // wen held across wack: a second identical write follows four cycles later.
    wen    = 1'b1;
    wsel   = 3'd5;
    wfield = 1'b1;
    wdata  = 28'h0000015;
    push_exp(5, 1'b1, 28'h0000015);
    wait_ack(3, 0, 0, 1'b1);
    push_exp(5, 1'b1, 28'h0000015);
    wait_ack(4, 0, 2, 1'b0);
    idle_chk();

    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_mmu_sysmap_cfg.md
CT_MMU_SYSMAP_CFG -- requirements
Module: ct_mmu_sysmap_cfg

Interface
REQ-001 SHALL have parameters: REGION_NUM, 8, number of sysmap regions; ADDR_W, 28, upper-address width (PA[39:12]); FLG_W, 5, region attribute width.
REQ-002 SHALL have ports:
- forever_cpuclk  in  1  sole clock.
- cpurst  in  1  reset; synchronous and active-high.
REQ-003 SHALL have port cp0_sysmap_wen  in  1  write request, held by cp0 until wack.
REQ-004 SHALL have port cp0_sysmap_wsel  in  3  target region index.
REQ-005 SHALL have port cp0_sysmap_wfield  in  1  0=upaddr, 1=flag.
REQ-006 SHALL have port cp0_sysmap_wdata  in  ADDR_W  write data; flag writes use [FLG_W-1:0].
REQ-007 SHALL have port mmu_sysmap_lookup_busy  in  1  sysmap lookups in flight.
REQ-008 SHALL have port sysmap_cp0_wack  out  1  one-cycle write completion pulse.
REQ-009 SHALL have port sysmap_cp0_werr  out  1  one-cycle rejection pulse, coincident with wack.
REQ-010 SHALL have port sysmap_mmu_upaddr_flat  out  REGION_NUM*ADDR_W  region upper bounds, region 0 in LSBs.
REQ-011 SHALL have port sysmap_mmu_flg_flat  out  REGION_NUM*FLG_W  region flags.
REQ-012 SHALL have port sysmap_mmu_update_pend  out  1  MMU must not start new lookups.
REQ-013 SHALL have port sysmap_mmu_cfg_chg  out  1  one-cycle pulse after a committed change (uTLB invalidate).

Function
REQ-014 SHALL implement FSM states IDLE, DRAIN, COMMIT, NOTIFY.
REQ-015 IDLE: wen=1 SHALL capture wsel/wfield/wdata into a staging register and go to DRAIN; wen is ignored outside IDLE.
REQ-016 DRAIN: SHALL stay while mmu_sysmap_lookup_busy=1 and go to COMMIT in the first cycle it is 0.
REQ-017 COMMIT: SHALL write the staged field into the selected region at the end of the cycle, unless rejected per REQ-024; then go to NOTIFY.
REQ-018 NOTIFY: SHALL assert wack=1 and cfg_chg=1 (cfg_chg=0 if rejected), then return to IDLE.
REQ-019 update_pend SHALL be 1 in DRAIN, COMMIT and NOTIFY, and 0 in IDLE.
REQ-020 Minimum latency: wen sampled in cycle N gives wack in N+3; each busy cycle in DRAIN adds one cycle.
REQ-021 New register values SHALL be visible on the outputs in the NOTIFY cycle; outputs SHALL remain stable during DRAIN.
REQ-022 A wen still high in the IDLE cycle after wack SHALL be treated as a new request; cp0 drops wen the cycle after wack.
REQ-023 A flag write SHALL update only the flag of the selected region; an upaddr write SHALL update only its upaddr.

Reset
REQ-024 (with SYSMAP_ORDER_CHK_EN) see REQ-029.
REQ-025 When cpurst=1 at a clock edge, the block SHALL go to IDLE and clear the staging register.
REQ-026 On reset, every upaddr SHALL be all-ones and every flag SHALL be FLG_RST.
REQ-027 On reset, wack, werr, cfg_chg and update_pend SHALL all be 0.
REQ-028 A reset during DRAIN, COMMIT or NOTIFY SHALL discard the staged write and SHALL NOT produce wack.

Configuration
REQ-029 With SYSMAP_ORDER_CHK_EN defined, an upaddr write SHALL be rejected (no update, werr=1) if the new value is below region[wsel-1].upaddr (for wsel>0) or above region[wsel+1].upaddr (for wsel<REGION_NUM-1); equal values are accepted.
REQ-030 Without SYSMAP_ORDER_CHK_EN, every write SHALL commit, werr SHALL be tied 0, and the checker SHALL be absent.

Structure
REQ-031 Package ct_mmu_sysmap_pkg SHALL hold REGION_NUM, ADDR_W, FLG_W, FLG_RST (5'b01111) and the FSM state enum, shared with the hit logic.
REQ-032 The ordering comparison SHALL be a sub-module, ct_mmu_sysmap_ordchk, instantiated only under SYSMAP_ORDER_CHK_EN.

Verification
REQ-033 Reset, then read the outputs -> every upaddr is 28'hFFFFFFF, every flag is 5'b01111, pend=0.
REQ-034 Write upaddr region 7 = 28'h0080000 with busy=0 -> wack at N+3; pend high N+1..N+3; cfg_chg pulses with wack.
REQ-035 Write flag region 2 = 5'b00011 with busy held high for 4 cycles -> wack at N+7; outputs unchanged before NOTIFY.
REQ-036 With ORDER_CHK: region1=28'h100, region2=28'h300, then write region1=28'h400 -> werr=1 with wack, cfg_chg=0, region1 stays 28'h100.
REQ-037 Assert cpurst in the DRAIN cycle -> no wack, register values unchanged, pend=0 the next cycle.
REQ-038 Hold wen high across wack -> second identical write is accepted, with a second wack 4 cycles after the first.
